fa_serial_adder: RTL and testbench
==================================

// Module: fa_serial_adder
// PURPOSE
//   Bit-serial N-bit adder built around the single-bit full adder (FA: X, Y, Z -> S, C).
//   It loads two operands and a carry-in on a start pulse, then feeds one bit pair per clock,
//   LSB first, into the FA, with the FA's C registered back to Z.
//   It presents the registered sum and carry-out with a one-cycle done pulse.
//   It is the sequential stage wrapped directly around the FA, consuming its S/C outputs.
// PARAMETERS
//   WIDTH   8   operand/sum width in bits; legal range 1..32
// PORTS
//   clk     in   1      rising-edge clock (the only clock)
//   rst_n   in   1      reset: asynchronous, active-low
//   start   in   1      request; sampled only in IDLE
//   a       in   WIDTH  operand A; captured on the accepted start edge
//   b       in   WIDTH  operand B; captured on the accepted start edge
//   cin     in   1      carry-in; captured on the accepted start edge
//   busy    out  1      high while in RUN
//   done    out  1      one-cycle pulse when sum/cout are newly valid
//   sum     out  WIDTH  (a+b+cin) mod 2^WIDTH, registered
//   cout    out  1      bit WIDTH of a+b+cin, registered
// BEHAVIOUR
//   - States: IDLE, RUN, DONE.
//     - Transitions: IDLE -(start)-> RUN; RUN -(WIDTH bits done)-> DONE; DONE -> IDLE (unconditional).
//   - Reset:
//     - rst_n low at any time, including mid-RUN, immediately forces: state=IDLE, busy=0, done=0,
//       sum=0, cout=0, and clears the internal shift registers, carry register and bit counter.
//     - The operation in flight is discarded.
//   - Accept:
//     - In IDLE, start=1 at edge k loads a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, state<=RUN.
//   - RUN:
//     - Each edge: FA(X=a_sr[0], Y=b_sr[0], Z=carry).
//     - s_sr <= {S, s_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1; carry <= C; cnt <= cnt+1.
//     - cnt width is clog2(WIDTH+1).
//   - Completion:
//     - On the edge that processes bit WIDTH-1 (edge k+WIDTH), sum <= final shifted value and
//       cout <= C; state <= DONE.
//   - Latency:
//     - busy=1 from edge k to edge k+WIDTH (exactly WIDTH cycles).
//     - done=1 for exactly the single cycle following edge k+WIDTH.
//     - IDLE is re-entered at edge k+WIDTH+1.
//   - sum and cout change only at the completion edge (or on reset). They hold the last result
//     otherwise, including throughout a following RUN.
//   - start while in RUN or DONE is ignored (not queued).
//   - start held high continuously produces back-to-back operations with one IDLE cycle between them.
//   - a, b and cin are don't-care outside the accept edge; changing them during RUN has no effect.
//   - Overflow wraps modulo 2^WIDTH; the lost bit appears on cout. No other status is produced.
//   - WIDTH=1 degenerates to one FA evaluation: busy for 1 cycle, then done.
// TESTING  (WIDTH=8 unless stated)
//   1. Reset: rst_n=0 at RUN cycle 3 of a=8'hAA, b=8'h55
//      -> busy/done/sum/cout = 0 immediately (before the next edge); IDLE after rst_n rises.
//   2. a=8'h00, b=8'h00, cin=0, start at edge k
//      -> busy high edges k..k+8; done high only in cycle k+8; sum=8'h00, cout=0.
//   3. Wrap: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, one done pulse.
//   4. Carry chain: a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//      Previous result held until that completion edge.
//   5. Ignored start: start a=8'h3C, b=8'h0A, cin=0, then pulse start with a=8'h11, b=8'h22
//      mid-RUN -> sum=8'h46, cout=0, single done.
//      start held high -> the next op accepted exactly 1 cycle after done.
//   6. WIDTH=1, all 8 (a, b, cin) combos -> {cout, sum} matches the FA truth table.
//      WIDTH=8, 1000 random ops -> match the a+b+cin model.

Source files
------------

// File: rtl/fa_serial_adder.sv
// -----------------------------------------------------------------------------
// fa_serial_adder
//   Bit-serial WIDTH-bit adder wrapped around a single full adder.
//   A start pulse in IDLE captures a, b and cin. The operands are then
//   consumed LSB first, one bit pair per clock. The full-adder carry is fed
//   back through a register. After WIDTH cycles the assembled sum and the
//   final carry are registered on sum/cout, and done pulses for one cycle.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request, sampled only in IDLE
//   a      in   WIDTH  operand A, captured on the accepted start edge
//   b      in   WIDTH  operand B, captured on the accepted start edge
//   cin    in   1      carry-in, captured on the accepted start edge
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse when sum/cout are newly valid
//   sum    out  WIDTH  (a+b+cin) mod 2^WIDTH, held until the next completion
//   cout   out  1      carry out of bit WIDTH-1, held with sum
// -----------------------------------------------------------------------------
module fa_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_s;
    logic             w_fa_c;
    logic             w_run;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum_final;

    // Single full adder evaluated on the current LSBs and the carry register.
    assign w_fa_s = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_fa_c = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));

    assign w_run    = (r_state == ST_RUN);
    assign w_last   = w_run && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept = (r_state == ST_IDLE) && start;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a_sr  <= r_a_sr >> 1;
            r_b_sr  <= r_b_sr >> 1;
            r_carry <= w_fa_c;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_sum_final;
                r_cout <= w_fa_c;
            end
        end
    end

    // Sum shift register. Only the WIDTH-1 already-computed bits need to be
    // stored: the final sum is the current S bit on top of those.
    generate
        if (WIDTH == 1) begin : gen_s_w1
            assign w_sum_final = w_fa_s;
        end else begin : gen_s_wn
            logic [WIDTH-2:0] r_s_sr;

            assign w_sum_final = {w_fa_s, r_s_sr};

            if (WIDTH == 2) begin : gen_s_w2
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_s_sr <= '0;
                    end else if (w_run) begin
                        r_s_sr <= w_fa_s;
                    end
                end
            end else begin : gen_s_wgt2
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_s_sr <= '0;
                    end else if (w_run) begin
                        r_s_sr <= {w_fa_s, r_s_sr[WIDTH-2:1]};
                    end
                end
            end
        end
    endgenerate

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_fa_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_fa_serial_adder
//   Bench for fa_serial_adder with two instances, WIDTH=8 and WIDTH=1.
//   Expected results come from plain integer addition a+b+cin.
// -----------------------------------------------------------------------------
module tb_fa_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fa_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    fa_serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation. Operand inputs are scrambled during RUN; with
    // inject set, a second start with other operands is pulsed mid-RUN.
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb,
                           input logic tc, input bit inject, input string tag);
        logic [8:0] exp;
        logic [7:0] prev_sum;
        logic       prev_cout;
        int         n;
        bit         held_ok;
        bit         busy_ok;
        prev_sum  = sum8;
        prev_cout = cout8;
        exp       = 9'(ta) + 9'(tb) + 9'(tc);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        tick();
        start8  = 1'b0;
        n       = 0;
        held_ok = 1'b1;
        busy_ok = 1'b1;
        while (!done8 && n < 40) begin
            if (!busy8) busy_ok = 1'b0;
            if (sum8 !== prev_sum || cout8 !== prev_cout) held_ok = 1'b0;
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            if (inject && n == 2) begin
                a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            tick();
            n++;
        end
        start8 = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'd8);
        chk({tag, " busy_run"}, 64'(busy_ok), 64'd1);
        chk({tag, " held"}, 64'(held_ok), 64'd1);
        chk({tag, " busy_done"}, 64'(busy8), 64'd0);
        chk({tag, " sum"}, 64'(sum8), 64'(exp[7:0]));
        chk({tag, " cout"}, 64'(cout8), 64'(exp[8]));
        tick();
        chk({tag, " done_pulse"}, 64'(done8), 64'd0);
        chk({tag, " idle"}, 64'(busy8), 64'd0);
        $display("op %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d cycles=%0d",
                 tag, ta, tb, tc, sum8, cout8, n);
    endtask

    initial begin
        logic [8:0] exp2;
        logic [1:0] exp1;
        int         n;

        // Reset state
        #2;
        chk("rst busy", 64'(busy8), 64'd0);
        chk("rst done", 64'(done8), 64'd0);
        chk("rst sum", 64'(sum8), 64'd0);
        chk("rst cout", 64'(cout8), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_op8(8'h00, 8'h00, 1'b0, 1'b0, "zero");
        run_op8(8'hFF, 8'h01, 1'b0, 1'b0, "wrap");
        run_op8(8'hFF, 8'hFF, 1'b1, 1'b0, "chain");

        // Reset during the third RUN cycle
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        chk("midrst busy_before", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy8), 64'd0);
        chk("midrst done", 64'(done8), 64'd0);
        chk("midrst sum", 64'(sum8), 64'd0);
        chk("midrst cout", 64'(cout8), 64'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst idle busy", 64'(busy8), 64'd0);
        chk("midrst idle done", 64'(done8), 64'd0);
        $display("op midrst: reset applied in RUN, outputs cleared");

        run_op8(8'h3C, 8'h0A, 1'b0, 1'b1, "ignored_start");

        // start held high: second op accepted one cycle after done
        a8 = 8'h5A; b8 = 8'hC3; cin8 = 1'b1; start8 = 1'b1;
        tick();
        a8 = 8'h81; b8 = 8'h90; cin8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        exp2 = 9'h05A + 9'h0C3 + 9'h001;
        chk("held op1 sum", 64'({cout8, sum8}), 64'(exp2));
        tick();
        chk("held gap busy", 64'(busy8), 64'd0);
        chk("held gap done", 64'(done8), 64'd0);
        tick();
        chk("held accept busy", 64'(busy8), 64'd1);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        exp2 = 9'h081 + 9'h090;
        chk("held op2 lat", 64'(n), 64'd8);
        chk("held op2 sum", 64'({cout8, sum8}), 64'(exp2));
        tick();
        $display("op held: back-to-back ops, sum=%02h cout=%0d", sum8, cout8);

        // WIDTH=1 truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk($sformatf("w1 %0d busy", i), 64'({busy1, done1}), 64'b10);
            tick();
            exp1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            chk($sformatf("w1 %0d done", i), 64'({busy1, done1}), 64'b01);
            chk($sformatf("w1 %0d result", i), 64'({cout1, sum1}), 64'(exp1));
            tick();
            chk($sformatf("w1 %0d idle", i), 64'({busy1, done1}), 64'b00);
            $display("op w1: x=%0d y=%0d z=%0d -> s=%0d c=%0d", v[2], v[1], v[0], sum1, cout1);
        end

        // Random WIDTH=8 ops
        for (int i = 0; i < 1000; i++) begin
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                    $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
